// File: rtl/instruction_fetch_unit.sv
// Purpose : fetch stage; holds the PC, fetches words over req/gnt/rvalid, buffers them and
//           presents the head instruction with its field slices to decode.
// Latency : inst_valid rises the cycle after the response cycle.
// Backpressure: inst_ready low holds the head stable. Fetch stops once buffered plus in-flight
//           words reach FIFO_DEPTH.
// Ports   : clk/rst_n; imem_req/addr/gnt/rvalid/rdata fetch port; redirect_valid/redirect_pc;
//           inst_valid/ready, inst, inst_pc, opcode/Funct3/Funct7/rs1/rs2/rd; misaligned_err.
// Option  : define IFU_PERF_CNT_EN to add fetch_cnt (instructions popped) and flush_cnt (redirects).
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        inst_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [6:0]  opcode,
    output logic [2:0]  Funct3,
    output logic [6:0]  Funct7,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        misaligned_err
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] flush_cnt
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    state_t state;

    // pc is the next address to launch (it advances when a request is launched, so a held,
    // already-killed request never disturbs the redirect target). rsp_pc is the address of the
    // next surviving response: responses are in order and survivors are always sequential.
    logic [31:0]   pc;
    logic [31:0]   rsp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] kill;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   buf_inst [FIFO_DEPTH];
    logic [31:0]   buf_pc   [FIFO_DEPTH];

    logic          redir_ok, redir_bad, granted, hold, resp, drop, push, pop, run_nxt, launch;
    logic [CW-1:0] outstanding_nxt, count_nxt;
    logic [CW:0]   occupancy;
    logic [31:0]   launch_pc;

    assign redir_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign granted   = imem_req && imem_gnt;
    assign hold      = imem_req && !imem_gnt;
    // A response with nothing outstanding (e.g. one arriving after reset) is ignored.
    assign resp      = imem_rvalid && (outstanding != '0);
    assign drop      = resp && (kill != '0);
    // Redirect wins over both the push of a response and the pop of the head.
    assign push      = resp && !drop && !redirect_valid;
    assign pop       = inst_valid && inst_ready && !redirect_valid;

    assign outstanding_nxt = outstanding + CW'(granted) - CW'(resp);
    assign count_nxt       = redirect_valid ? '0 : (count + CW'(push) - CW'(pop));
    assign occupancy       = {1'b0, count_nxt} + {1'b0, outstanding_nxt};
    assign run_nxt         = (state == HALT) ? redir_ok : !redir_bad;
    assign launch          = !hold && run_nxt && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign launch_pc       = redir_ok ? redirect_pc : pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            rsp_pc         <= RESET_PC;
            imem_req       <= 1'b0;
            imem_addr      <= '0;
            outstanding    <= '0;
            kill           <= '0;
            count          <= '0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            misaligned_err <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                buf_inst[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else begin
            case (state)
                IDLE:    state <= redir_bad ? HALT : RUN;
                RUN:     if (redir_bad) state <= HALT;
                HALT:    if (redir_ok) state <= RUN;
                default: state <= IDLE;
            endcase

            misaligned_err <= redir_bad;
            outstanding    <= outstanding_nxt;
            count          <= count_nxt;

            // Everything still owed by memory, including a request waiting for gnt, is stale.
            if (redirect_valid) begin
                kill <= outstanding_nxt + CW'(hold);
            end else if (drop) begin
                kill <= kill - CW'(1);
            end

            if (launch) begin
                imem_req  <= 1'b1;
                imem_addr <= launch_pc;
                pc        <= launch_pc + 32'd4;
            end else begin
                if (!hold) imem_req <= 1'b0;
                if (redir_ok) pc <= redirect_pc;
            end

            if (redirect_valid) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (push) begin
                    buf_inst[wr_ptr] <= imem_rdata;
                    buf_pc[wr_ptr]   <= rsp_pc;
                    wr_ptr           <= wr_ptr + PW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
            end

            if (redir_ok) begin
                rsp_pc <= redirect_pc;
            end else if (push) begin
                rsp_pc <= rsp_pc + 32'd4;
            end
        end
    end

    assign inst_valid = (count != '0);
    assign inst       = buf_inst[rd_ptr];
    assign inst_pc    = buf_pc[rd_ptr];
    assign opcode     = inst[6:0];
    assign Funct3     = inst[14:12];
    assign Funct7     = inst[31:25];
    assign rs1        = inst[19:15];
    assign rs2        = inst[24:20];
    assign rd         = inst[11:7];

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (pop) fetch_cnt <= fetch_cnt + 32'd1;
            if (redirect_valid) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid, inst_ready, inst_valid, misaligned_err;
    logic [31:0] redirect_pc, inst, inst_pc;
    logic [6:0]  opcode, Funct7;
    logic [2:0]  Funct3;
    logic [4:0]  rs1, rs2, rd;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_ready(inst_ready), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .opcode(opcode), .Funct3(Funct3), .Funct7(Funct7), .rs1(rs1), .rs2(rs2), .rd(rd),
        .misaligned_err(misaligned_err)
`ifdef IFU_PERF_CNT_EN
        , .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // stimulus knobs
    int gnt_pct = 100, ready_pct = 100, lat_max = 1, redir_pct = 0;
    logic        arm_redir = 1'b0;
    logic [31:0] arm_tgt = '0;

    // memory model: in-order responses to granted addresses
    logic [31:0] q_addr[$];
    int          q_due[$];
    int          last_due = 0;

    // stream model: after reset/redirect to T, decode must see T, T+4, T+8, ...
    logic [31:0] exp_pc = '0;
    logic        halted = 1'b0, flush_exp = 1'b0, mis_exp = 1'b0, post_reset = 1'b0;
    int          pops = 0, flushes = 0;
    logic [31:0] popped[$];
    logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_redir = 1'b0;
    logic        prev_req = 1'b0, prev_gnt = 1'b0;
    logic [31:0] prev_addr = '0, prev_pc = '0, prev_inst = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: checks outputs every cycle, then advances the model over the coming edge.
    always @(negedge clk) begin
        logic [31:0] w;
        if (!rst_n) begin
            chk1("rst_req", imem_req, 1'b0);
            chk1("rst_valid", inst_valid, 1'b0);
            chk32("rst_inst", inst, 32'h0);
            chk32("rst_inst_pc", inst_pc, 32'h0);
            chk1("rst_mis", misaligned_err, 1'b0);
`ifdef IFU_PERF_CNT_EN
            chk32("rst_fetch_cnt", fetch_cnt, 32'h0);
            chk32("rst_flush_cnt", flush_cnt, 32'h0);
`endif
            exp_pc = 32'h0; halted = 1'b0; flush_exp = 1'b0; mis_exp = 1'b0;
            post_reset = 1'b1; pops = 0; flushes = 0;
            prev_valid = 1'b0; prev_req = 1'b0; prev_gnt = 1'b0; prev_redir = 1'b0;
        end else begin
            if (post_reset) chk1("idle_no_req", imem_req, 1'b0);
            post_reset = 1'b0;
            chk1("misaligned_err", misaligned_err, mis_exp);
            if (flush_exp || halted) begin
                chk1("flushed_or_halted_valid", inst_valid, 1'b0);
            end else if (inst_valid) begin
                w = mem_word(exp_pc);
                chk32("inst_pc", inst_pc, exp_pc);
                chk32("inst", inst, w);
                chk32("opcode", 32'(opcode), 32'(w[6:0]));
                chk32("Funct3", 32'(Funct3), 32'(w[14:12]));
                chk32("Funct7", 32'(Funct7), 32'(w[31:25]));
                chk32("rs1", 32'(rs1), 32'(w[19:15]));
                chk32("rs2", 32'(rs2), 32'(w[24:20]));
                chk32("rd", 32'(rd), 32'(w[11:7]));
            end
            if (prev_valid && !prev_ready && !prev_redir) begin
                chk1("stall_valid_stable", inst_valid, 1'b1);
                chk32("stall_pc_stable", inst_pc, prev_pc);
                chk32("stall_inst_stable", inst, prev_inst);
            end
            if (prev_req && !prev_gnt) begin
                chk1("req_held", imem_req, 1'b1);
                chk32("addr_held", imem_addr, prev_addr);
            end else if (halted) begin
                chk1("halt_no_req", imem_req, 1'b0);
            end
            if (imem_req) chk32("addr_aligned", 32'(imem_addr[1:0]), 32'h0);
`ifdef IFU_PERF_CNT_EN
            chk32("fetch_cnt", fetch_cnt, 32'(pops));
            chk32("flush_cnt", flush_cnt, 32'(flushes));
`endif
            mis_exp = 1'b0;
            flush_exp = 1'b0;
            if (redirect_valid) begin
                flushes++;
                flush_exp = 1'b1;
                if (redirect_pc[1:0] != 2'b00) begin
                    mis_exp = 1'b1;
                    halted = 1'b1;
                end else begin
                    halted = 1'b0;
                    exp_pc = redirect_pc;
                end
            end else if (inst_valid && inst_ready) begin
                popped.push_back(inst_pc);
                pops++;
                exp_pc = exp_pc + 32'd4;
            end
            prev_valid = inst_valid; prev_ready = inst_ready; prev_redir = redirect_valid;
            prev_req = imem_req; prev_gnt = imem_gnt; prev_addr = imem_addr;
            prev_pc = inst_pc; prev_inst = inst;
        end
    end

    task automatic drive_cycle(input logic redir, input logic [31:0] tgt);
        logic [31:0] a, t;
        logic        r;
        int          due;
        @(posedge clk);
        #1;
        cyc++;
        if (q_addr.size() != 0 && q_due[0] <= cyc) begin
            a = q_addr.pop_front();
            void'(q_due.pop_front());
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(a);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        imem_gnt = imem_req && (int'($urandom_range(99)) < gnt_pct);
        if (imem_gnt) begin
            due = cyc + int'($urandom_range(lat_max, 1));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            q_addr.push_back(imem_addr);
            q_due.push_back(due);
        end
        inst_ready = (int'($urandom_range(99)) < ready_pct);
        r = redir;
        t = tgt;
        if (!r && redir_pct > 0 && int'($urandom_range(99)) < redir_pct) begin
            r = 1'b1;
            t = $urandom & 32'h0000_3FFC;
            if ($urandom_range(4) == 0) t[1:0] = 2'($urandom_range(3, 1));
        end
        if (!r && arm_redir && imem_rvalid && inst_valid) begin
            r = 1'b1;
            t = arm_tgt;
            arm_redir = 1'b0;
        end
        redirect_valid = r;
        redirect_pc    = r ? t : $urandom;
    endtask

    // Reset for a few cycles; on release, present a stale response that must be ignored.
    task automatic do_reset(input int hold_cycles);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
        q_addr.delete();
        q_due.delete();
        last_due = cyc;
        repeat (hold_cycles) @(posedge clk);
        #1;
        rst_n = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        inst_ready = 1'b1;
    endtask

    task automatic wait_pops(input int n, input int budget, input string name);
        int target, k;
        target = popped.size() + n;
        k = 0;
        while (popped.size() < target && k < budget) begin
            drive_cycle(1'b0, 32'h0);
            k++;
        end
        @(negedge clk);
        chk32(name, 32'(popped.size() >= target ? target : popped.size()), 32'(target));
    endtask

    initial begin
        int base, k;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        do_reset(3);

        // 1: streaming from reset
        base = popped.size();
        wait_pops(3, 60, "t1_progress");
        chk32("t1_pc0", popped[base], 32'h0);
        chk32("t1_pc1", popped[base+1], 32'h4);
        chk32("t1_pc2", popped[base+2], 32'h8);

        // 2: decode stalled for 10 cycles
        do_reset(2);
        ready_pct = 0;
        repeat (10) drive_cycle(1'b0, 32'h0);
        @(negedge clk);
        chk1("t2_req_off", imem_req, 1'b0);
        chk1("t2_valid", inst_valid, 1'b1);
        chk32("t2_head_pc", inst_pc, 32'h0);
        ready_pct = 100;
        base = popped.size();
        wait_pops(3, 60, "t2_progress");
        chk32("t2_pc0", popped[base], 32'h0);
        chk32("t2_pc1", popped[base+1], 32'h4);
        chk32("t2_pc2", popped[base+2], 32'h8);

        // 3: redirect with two requests in flight
        lat_max = 4;
        k = 0;
        while (q_addr.size() < 2 && k < 100) begin
            drive_cycle(1'b0, 32'h0);
            k++;
        end
        chk1("t3_two_inflight", q_addr.size() >= 2, 1'b1);
        drive_cycle(1'b1, 32'h100);
        base = popped.size();
        wait_pops(2, 80, "t3_progress");
        chk32("t3_pc0", popped[base], 32'h100);
        chk32("t3_pc1", popped[base+1], 32'h104);

        // 4: redirect coincides with a response and a ready head
        lat_max = 1;
        arm_tgt = 32'h300;
        arm_redir = 1'b1;
        k = 0;
        while (arm_redir && k < 100) begin
            drive_cycle(1'b0, 32'h0);
            k++;
        end
        chk1("t4_redirect_hit", arm_redir, 1'b0);
        arm_redir = 1'b0;
        base = popped.size();
        wait_pops(1, 60, "t4_progress");
        chk32("t4_pc0", popped[base], 32'h300);

        // 5: misaligned redirect halts until an aligned one arrives
        drive_cycle(1'b1, 32'h102);
        drive_cycle(1'b0, 32'h0);
        @(negedge clk);
        chk1("t5_mis_pulse", misaligned_err, 1'b1);
        repeat (10) drive_cycle(1'b0, 32'h0);
        @(negedge clk);
        chk1("t5_req_off", imem_req, 1'b0);
        chk1("t5_mis_done", misaligned_err, 1'b0);
        drive_cycle(1'b1, 32'h200);
        base = popped.size();
        wait_pops(2, 60, "t5_progress");
        chk32("t5_pc0", popped[base], 32'h200);
        chk32("t5_pc1", popped[base+1], 32'h204);

        // PC wrap at 2^32
        drive_cycle(1'b1, 32'hFFFF_FFF8);
        base = popped.size();
        wait_pops(4, 80, "wrap_progress");
        chk32("wrap_pc0", popped[base], 32'hFFFF_FFF8);
        chk32("wrap_pc1", popped[base+1], 32'hFFFF_FFFC);
        chk32("wrap_pc2", popped[base+2], 32'h0);
        chk32("wrap_pc3", popped[base+3], 32'h4);

        // randomized traffic
        gnt_pct = 70; ready_pct = 70; lat_max = 4; redir_pct = 3;
        repeat (2000) drive_cycle(1'b0, 32'h0);
        redir_pct = 0; gnt_pct = 100; ready_pct = 100;
        drive_cycle(1'b1, 32'h400);
        base = popped.size();
        wait_pops(1, 80, "rand_recover");
        chk32("rand_recover_pc", popped[base], 32'h400);

        // 6: reset with two requests outstanding
        lat_max = 3;
        k = 0;
        while (q_addr.size() < 2 && k < 100) begin
            drive_cycle(1'b0, 32'h0);
            k++;
        end
        chk1("t6_two_inflight", q_addr.size() >= 2, 1'b1);
        do_reset(2);
        base = popped.size();
        wait_pops(2, 60, "t6_progress");
        chk32("t6_pc0", popped[base], 32'h0);
        chk32("t6_pc1", popped[base+1], 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
